// File: rtl/dmem_access_unit.sv
// Load/store access unit: decodes byte lanes from address and size, runs the
// data-memory bus handshake and traps misaligned accesses without touching the bus.
module dmem_access_unit (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ren,
    input  logic        wen,
    input  logic [2:0]  load_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        done,
    output logic        misaligned,
    output logic [31:0] dmem_out,
    output logic [3:0]  byte_en,
    output logic        bus_ren,
    output logic        bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byte_en,
    input  logic        bus_busy,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    // Returns {misaligned, lane_mask}; size 2'b11 has no legal lane pattern.
    function automatic logic [4:0] lane_decode(input logic [1:0] size, input logic [1:0] offset);
        logic [4:0] res;
        case (size)
            2'b00: res = {1'b0, 4'b0001 << offset};
            2'b01: begin
                case (offset)
                    2'b00:   res = 5'b0_0011;
                    2'b10:   res = 5'b0_1100;
                    default: res = 5'b1_0000;
                endcase
            end
            2'b10: res = (offset == 2'b00) ? 5'b0_1111 : 5'b1_0000;
            default: res = 5'b1_0000;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] res;
        case (size)
            2'b00:   res = {4{data[7:0]}};
            2'b01:   res = {2{data[15:0]}};
            default: res = data;
        endcase
        return res;
    endfunction

    state_t      r_state;
    logic        r_squash;
    logic        r_done;
    logic        r_misaligned;
    logic [31:0] r_dmem_out;
    logic [3:0]  r_byte_en;
    logic        r_bus_ren;
    logic        r_bus_wen;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_byte_en;

    logic [4:0]  w_lane;
    logic        w_misaligned;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata_rep;
    logic        w_req;
    logic        w_unused_sign;

    // Lane decode, store replication and request qualification.
    always_comb begin
        w_lane        = lane_decode(load_type[1:0], addr[1:0]);
        w_misaligned  = w_lane[4];
        w_mask        = w_lane[3:0];
        w_wdata_rep   = replicate(load_type[1:0], wdata);
        w_req         = (ren | wen) & ~flush;
        w_unused_sign = load_type[2];
    end

    // Access sequencer; bus side and completion outputs are all registered here.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state       <= ST_IDLE;
            r_squash      <= 1'b0;
            r_done        <= 1'b0;
            r_misaligned  <= 1'b0;
            r_dmem_out    <= 32'h0000_0000;
            r_byte_en     <= 4'b0000;
            r_bus_ren     <= 1'b0;
            r_bus_wen     <= 1'b0;
            r_bus_addr    <= 32'h0000_0000;
            r_bus_wdata   <= 32'h0000_0000;
            r_bus_byte_en <= 4'b0000;
        end else begin
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_misaligned) begin
                            r_state      <= ST_ERR;
                            r_done       <= 1'b1;
                            r_misaligned <= 1'b1;
                            r_byte_en    <= 4'b0000;
                        end else begin
                            // A store wins when both strobes are requested.
                            r_state       <= ST_ACCESS;
                            r_bus_ren     <= ren & ~wen;
                            r_bus_wen     <= wen;
                            r_bus_addr    <= {addr[31:2], 2'b00};
                            r_bus_wdata   <= w_wdata_rep;
                            r_bus_byte_en <= w_mask;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (flush) begin
                        r_squash <= 1'b1;
                    end
                    if (!bus_busy) begin
                        r_state       <= ST_DONE;
                        r_bus_ren     <= 1'b0;
                        r_bus_wen     <= 1'b0;
                        r_bus_byte_en <= 4'b0000;
                        r_byte_en     <= r_bus_byte_en;
                        r_done        <= ~(r_squash | flush);
                        if (r_bus_ren) begin
                            r_dmem_out <= bus_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_squash <= 1'b0;
                end
                ST_ERR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A flush arriving in the completion cycle still cancels the pulse.
    assign done        = r_done & ~flush;
    assign misaligned  = r_misaligned & ~flush;
    assign dmem_out    = r_dmem_out;
    assign byte_en     = r_byte_en;
    assign bus_ren     = r_bus_ren;
    assign bus_wen     = r_bus_wen;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign bus_byte_en = r_bus_byte_en;

endmodule
